// File: rtl/raster_cmd_queue.sv
// Command FIFO between the core's gpu_submit path and the rasterizer.
// Show-ahead head register, sticky overflow, and idle/full status.
package common;
    typedef enum logic [1:0] {
        CMD_FILL  = 2'd0,
        CMD_POINT = 2'd1,
        CMD_LINE  = 2'd2
    } raster_command_t;
endpackage

module raster_cmd_queue
    import common::*;
#(
    parameter int DEPTH         = 4,
    parameter int OPERAND_WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     gpu_submit,
    input  raster_command_t          gpu_command,
    input  logic [OPERAND_WIDTH-1:0] gpu_operands,
    output logic                     queue_full,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic                     gpu_idle,
    output logic                     raster_cmd_valid,
    input  logic                     raster_cmd_ready,
    output raster_command_t          raster_command,
    output logic [OPERAND_WIDTH-1:0] raster_operands,
    input  logic                     raster_idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $bits(raster_command_t);
    localparam int EW = CW + OPERAND_WIDTH;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head_q;
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr_n;
    logic [AW:0]   count;
    logic [AW:0]   count_n;
    logic [AW:0]   remain;
    logic          pop;
    logic          push;
    logic          full_now;
    logic          ovf_evt;

    assign full_now = (count == FULL_CNT);
    assign pop      = raster_cmd_valid & raster_cmd_ready;
    assign push     = gpu_submit & (~full_now | pop);
    assign ovf_evt  = gpu_submit & full_now & ~pop;
    assign rptr_n   = rptr + AW'(pop);
    // Entries already stored before this edge that survive the pop;
    // a same-cycle push only becomes visible one cycle later.
    assign remain   = count - (AW+1)'(pop);
    assign count_n  = remain + (AW+1)'(push);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr             <= '0;
            wptr             <= '0;
            count            <= '0;
            raster_cmd_valid <= 1'b0;
            queue_full       <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            rptr             <= rptr_n;
            count            <= count_n;
            raster_cmd_valid <= (remain != '0);
            queue_full       <= (count_n == FULL_CNT);
            if (push)
                wptr <= wptr + AW'(1);
            if (ovf_evt)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wptr] <= {gpu_command, gpu_operands};
        head_q <= mem[rptr_n];
    end

    assign raster_command  = raster_command_t'(head_q[EW-1 -: CW]);
    assign raster_operands = head_q[OPERAND_WIDTH-1:0];
    assign gpu_idle = (count == '0) & ~raster_cmd_valid & raster_idle;

endmodule

// File: tb/tb_raster_cmd_queue.sv
// Directed bench for raster_cmd_queue with a queue-based reference
// model compared every cycle, plus literal drain-order checks.
module tb_raster_cmd_queue;
    import common::*;

    localparam int DEPTH = 4;
    localparam int OW    = 40;

    logic            clk;
    logic            rst_n;
    logic            submit;
    raster_command_t cmd;
    logic [OW-1:0]   ops;
    logic            full;
    logic            ovf;
    logic            clr;
    logic            idle;
    logic            valid;
    logic            ready;
    raster_command_t r_cmd;
    logic [OW-1:0]   r_ops;
    logic            ridle;

    raster_cmd_queue #(.DEPTH(DEPTH), .OPERAND_WIDTH(OW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .gpu_submit       (submit),
        .gpu_command      (cmd),
        .gpu_operands     (ops),
        .queue_full       (full),
        .overflow         (ovf),
        .overflow_clr     (clr),
        .gpu_idle         (idle),
        .raster_cmd_valid (valid),
        .raster_cmd_ready (ready),
        .raster_command   (r_cmd),
        .raster_operands  (r_ops),
        .raster_idle      (ridle)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    logic [41:0] q[$];
    logic [41:0] dlog[$];
    logic [41:0] ex[$];
    logic        m_valid;
    logic        m_full;
    logic        m_ovf;
    logic [41:0] m_head;

    function automatic logic [41:0] mk(input logic [1:0] c, input logic [OW-1:0] o);
        return {c, o};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic pop;
        logic push;
        if (!rst_n) begin
            q.delete();
            m_valid = 1'b0;
            m_full  = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            pop  = m_valid && ready;
            push = submit && (q.size() < DEPTH || pop);
            if (submit && q.size() == DEPTH && !pop)
                m_ovf = 1'b1;
            else if (clr)
                m_ovf = 1'b0;
            if (pop)
                void'(q.pop_front());
            m_valid = (q.size() != 0);
            if (m_valid)
                m_head = q[0];
            if (push)
                q.push_back(mk(cmd, ops));
            m_full = (q.size() == DEPTH);
        end
    endtask

    task automatic compare_all();
        chk("valid", 64'(valid), 64'(m_valid));
        chk("queue_full", 64'(full), 64'(m_full));
        chk("overflow", 64'(ovf), 64'(m_ovf));
        chk("gpu_idle", 64'(idle), 64'(q.size() == 0 && !m_valid && ridle));
        if (m_valid)
            chk("head", 64'({r_cmd, r_ops}), 64'(m_head));
    endtask

    task automatic tick();
        if (rst_n && valid && ready)
            dlog.push_back({r_cmd, r_ops});
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_len"}, 64'(dlog.size()), 64'(ex.size()));
        for (int i = 0; i < ex.size() && i < dlog.size(); i++)
            chk(nm, 64'(dlog[i]), 64'(ex[i]));
        dlog.delete();
        ex.delete();
    endtask

    initial begin
        logic [1:0] c2;
        clk    = 1'b0;
        rst_n  = 1'b0;
        submit = 1'b0;
        cmd    = CMD_FILL;
        ops    = '0;
        ready  = 1'b0;
        clr    = 1'b0;
        ridle  = 1'b1;
        m_head = '0;
        tick();
        tick();
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);

        // single FILL command
        rst_n  = 1'b1;
        submit = 1'b1;
        cmd    = CMD_FILL;
        ops    = 40'h3C;
        ready  = 1'b1;
        tick();
        submit = 1'b0;
        chk("single_busy", 64'(idle), 64'd0);
        repeat (4) tick();
        ex.push_back(mk(CMD_FILL, 40'h3C));
        check_log("single");
        chk("single_idle", 64'(idle), 64'd1);

        // fill to full, overflow, drain
        ready = 1'b0;
        ridle = 1'b0;
        for (int i = 0; i < 4; i++) begin
            submit = 1'b1;
            cmd = (i == 1) ? CMD_LINE : (i == 2) ? CMD_FILL : CMD_POINT;
            ops = 40'(i + 1);
            tick();
        end
        submit = 1'b0;
        chk("full_after4", 64'(full), 64'd1);
        submit = 1'b1;
        cmd    = CMD_LINE;
        ops    = 40'd5;
        tick();
        submit = 1'b0;
        tick();
        chk("ovf_set", 64'(ovf), 64'd1);
        ready = 1'b1;
        repeat (6) tick();
        ready = 1'b0;
        ex.push_back(mk(CMD_POINT, 40'd1));
        ex.push_back(mk(CMD_LINE, 40'd2));
        ex.push_back(mk(CMD_FILL, 40'd3));
        ex.push_back(mk(CMD_POINT, 40'd4));
        check_log("drain4");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovf_clr", 64'(ovf), 64'd0);

        // simultaneous push and pop at full
        for (int i = 0; i < 4; i++) begin
            submit = 1'b1;
            cmd    = CMD_LINE;
            ops    = 40'(8'hA1 + i);
            tick();
        end
        submit = 1'b0;
        tick();
        submit = 1'b1;
        cmd    = CMD_POINT;
        ops    = 40'd9;
        ready  = 1'b1;
        tick();
        submit = 1'b0;
        chk("pp_full", 64'(full), 64'd1);
        chk("pp_no_ovf", 64'(ovf), 64'd0);
        repeat (7) tick();
        ready = 1'b0;
        for (int i = 0; i < 4; i++)
            ex.push_back(mk(CMD_LINE, 40'(8'hA1 + i)));
        ex.push_back(mk(CMD_POINT, 40'd9));
        check_log("pushpop");

        // backpressure and pointer wrap, includes undefined encoding 3
        for (int i = 0; i < 20; i++) begin
            ready  = (i % 4 == 0) || (i % 4 == 3);
            submit = (i % 2 == 0);
            c2     = 2'((i / 2) % 4);
            cmd    = raster_command_t'(c2);
            ops    = 40'(20 + i / 2);
            tick();
        end
        submit = 1'b0;
        ready  = 1'b1;
        repeat (8) tick();
        ready = 1'b0;
        for (int i = 0; i < 10; i++)
            ex.push_back(mk(2'(i % 4), 40'(20 + i)));
        check_log("wrap");
        chk("wrap_no_ovf", 64'(ovf), 64'd0);

        // reset with queued entries and a pending overflow
        for (int i = 0; i < 5; i++) begin
            submit = 1'b1;
            cmd    = CMD_FILL;
            ops    = 40'(31 + i);
            tick();
        end
        submit = 1'b0;
        tick();
        chk("pre_rst_ovf", 64'(ovf), 64'd1);
        rst_n  = 1'b0;
        submit = 1'b1;
        ops    = 40'hEE;
        tick();
        chk("mid_rst_valid", 64'(valid), 64'd0);
        chk("mid_rst_full", 64'(full), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        rst_n  = 1'b1;
        submit = 1'b1;
        cmd    = CMD_FILL;
        ops    = 40'd7;
        ready  = 1'b1;
        tick();
        submit = 1'b0;
        repeat (4) tick();
        ex.push_back(mk(CMD_FILL, 40'd7));
        check_log("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
